// File: rtl/pc_branch_ctrl_pkg.sv
// rtl/pc_branch_ctrl_pkg.sv - shared address width, reset vector and FSM encoding for pc_branch_ctrl
package pc_branch_ctrl_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam logic [ADDR_BUS-1:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_target_latch.sv
// rtl/pc_branch_ctrl_target_latch.sv - pending branch target register with valid bit
// clear wins over load so a flush in the same cycle as a new latch request leaves nothing pending.
module pc_target_latch #(
  parameter int unsigned ADDR_W = pc_branch_ctrl_pkg::ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] target,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (load) begin
      target <= load_addr;
      valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - fetch PC sequencer: flush, stall, branch hold and delay-slot tracking
// Optional PC_ALIGN_CHECK_EN: reject misaligned branch/flush targets and report them on addr_err/addr_err_pc.
module pc_branch_ctrl #(
  parameter int unsigned       ADDR_W   = pc_branch_ctrl_pkg::ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = pc_branch_ctrl_pkg::RESET_PC,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              next_inst_delayslot_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              rom_en,
  output logic              delayslot_flag,
`ifdef PC_ALIGN_CHECK_EN
  output logic              addr_err,
  output logic [ADDR_W-1:0] addr_err_pc,
`endif
  output logic              branch_pending
);

  import pc_branch_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_load;
  logic              tgt_clear;
  logic              tgt_valid;
  logic              flush_act;
  logic              branch_act;
  logic              flush_bad;
  logic              branch_bad;

  assign pc_seq     = pc + STEP;
  // Flush is meaningless before the first fetch has been issued.
  assign flush_act  = flush && (state != S_RESET);
  // A branch sitting in a delay slot is architecturally undefined; drop it.
  assign branch_act = branch_flag && !delayslot_flag;

`ifdef PC_ALIGN_CHECK_EN
  assign flush_bad  = is_misaligned(flush_pc[1:0]);
  assign branch_bad = is_misaligned(branch_addr[1:0]);
`else
  assign flush_bad  = 1'b0;
  assign branch_bad = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    tgt_load   = 1'b0;
    tgt_clear  = 1'b0;
    if (flush_act) begin
      state_next = S_FETCH;
      tgt_clear  = 1'b1;
      if (!flush_bad) begin
        pc_next = flush_pc;
      end else if (!stall_if) begin
        pc_next = pc_seq;
      end
    end else begin
      case (state)
        S_RESET: begin
          state_next = S_FETCH;
        end
        S_FETCH: begin
          if (branch_act && !branch_bad) begin
            if (stall_if) begin
              tgt_load   = 1'b1;
              state_next = S_HOLD;
            end else begin
              pc_next = branch_addr;
            end
          end else if (!stall_if) begin
            pc_next = pc_seq;
          end
        end
        S_HOLD: begin
          // ID is frozen and keeps presenting the same branch, so it is not re-latched.
          if (!stall_if) begin
            pc_next    = tgt_addr;
            tgt_clear  = 1'b1;
            state_next = S_FETCH;
          end
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_RESET;
      pc             <= RESET_PC;
      rom_en         <= 1'b0;
      delayslot_flag <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      rom_en <= 1'b1;
      if (flush_act) begin
        delayslot_flag <= 1'b0;
      end else if (!stall_id) begin
        delayslot_flag <= next_inst_delayslot_flag;
      end
    end
  end

  pc_target_latch #(
    .ADDR_W (ADDR_W)
  ) u_target_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tgt_load),
    .clear     (tgt_clear),
    .load_addr (branch_addr),
    .target    (tgt_addr),
    .valid     (tgt_valid)
  );

  assign branch_pending = tgt_valid;

`ifdef PC_ALIGN_CHECK_EN
  logic              err_hit;
  logic [ADDR_W-1:0] err_addr;

  always_comb begin
    err_hit  = 1'b0;
    err_addr = addr_err_pc;
    if (flush_act) begin
      if (flush_bad) begin
        err_hit  = 1'b1;
        err_addr = flush_pc;
      end
    end else if ((state == S_FETCH) && branch_act && branch_bad) begin
      err_hit  = 1'b1;
      err_addr = branch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err    <= 1'b0;
      addr_err_pc <= '0;
    end else begin
      addr_err    <= err_hit;
      addr_err_pc <= err_addr;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - vector table, corner sequences and randomized model check for pc_branch_ctrl
module tb_pc_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush, branch_flag, nds;
  logic [31:0] flush_pc, branch_addr;
  logic [31:0] pc;
  logic        rom_en, delayslot_flag, branch_pending;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err;
  logic [31:0] addr_err_pc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_branch_ctrl dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .stall_if                 (stall_if),
    .stall_id                 (stall_id),
    .flush                    (flush),
    .flush_pc                 (flush_pc),
    .branch_flag              (branch_flag),
    .branch_addr              (branch_addr),
    .next_inst_delayslot_flag (nds),
    .pc                       (pc),
    .rom_en                   (rom_en),
    .delayslot_flag           (delayslot_flag),
`ifdef PC_ALIGN_CHECK_EN
    .addr_err                 (addr_err),
    .addr_err_pc              (addr_err_pc),
`endif
    .branch_pending           (branch_pending)
  );

  typedef struct {
    logic        s_if;
    logic        s_id;
    logic        fl;
    logic [31:0] fl_pc;
    logic        br;
    logic [31:0] br_addr;
    logic        nd;
    logic [31:0] e_pc;
    logic        e_ds;
    logic        e_pend;
  } vec_t;

  vec_t vq[$];

  // Reference model state: plain booleans and arithmetic, one update per clock.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_started, m_pending, m_ds;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic s_if, input logic s_id, input logic fl, input logic [31:0] fl_pc,
                         input logic br, input logic [31:0] br_addr, input logic nd,
                         input logic [31:0] e_pc, input logic e_ds, input logic e_pend);
    vec_t v;
    v.s_if = s_if; v.s_id = s_id; v.fl = fl; v.fl_pc = fl_pc;
    v.br = br; v.br_addr = br_addr; v.nd = nd;
    v.e_pc = e_pc; v.e_ds = e_ds; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  task automatic drive(input logic s_if, input logic s_id, input logic fl, input logic [31:0] fl_pc,
                       input logic br, input logic [31:0] br_addr, input logic nd);
    stall_if = s_if; stall_id = s_id; flush = fl; flush_pc = fl_pc;
    branch_flag = br; branch_addr = br_addr; nds = nd;
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_tgt = '0;
    m_started = 0; m_pending = 0; m_ds = 0;
  endtask

  task automatic model_step();
    bit old_ds;
    old_ds = m_ds;
    if (!m_started) begin
      m_started = 1;
      if (!stall_id) m_ds = nds;
    end else if (flush) begin
      m_pc = flush_pc; m_pending = 0; m_ds = 0;
    end else begin
      if (!stall_id) m_ds = nds;
      if (m_pending) begin
        if (!stall_if) begin m_pc = m_tgt; m_pending = 0; end
      end else if (branch_flag && !old_ds) begin
        if (stall_if) begin m_pending = 1; m_tgt = branch_addr; end
        else m_pc = branch_addr;
      end else if (!stall_if) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc, 32'hBFC0_0000);
    chk("reset rom_en", {31'd0, rom_en}, 32'd0);
    chk("reset ds", {31'd0, delayslot_flag}, 32'd0);
    chk("reset pend", {31'd0, branch_pending}, 32'd0);
    rst_n = 1'b1;
    chk("cycle0 pc", pc, 32'hBFC0_0000);
    chk("cycle0 rom_en", {31'd0, rom_en}, 32'd0);

    //       s_if s_id fl fl_pc          br  br_addr       nd  e_pc           ds pend
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_0000, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_0004, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_0008, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_000C, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_0010, 0, 0);
    add_vec(0, 0, 0, 32'h0,         1, 32'hBFC0_0100, 1, 32'hBFC0_0100, 1, 0);
    add_vec(0, 0, 0, 32'h0,         1, 32'h1234_5678, 0, 32'hBFC0_0104, 0, 0);
    add_vec(1, 0, 0, 32'h0,         1, 32'h0040_0020, 0, 32'hBFC0_0104, 0, 1);
    add_vec(1, 0, 0, 32'h0,         1, 32'h0040_0020, 0, 32'hBFC0_0104, 0, 1);
    add_vec(1, 0, 0, 32'h0,         1, 32'h0040_0020, 0, 32'hBFC0_0104, 0, 1);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0020, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0024, 0, 0);
    add_vec(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0028, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_002C, 1, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0030, 0, 0);
    add_vec(1, 0, 0, 32'h0,         1, 32'h0050_0000, 0, 32'h0040_0030, 0, 1);
    add_vec(1, 0, 1, 32'hBFC0_0380, 1, 32'h0060_0000, 1, 32'hBFC0_0380, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hBFC0_0384, 0, 0);
    add_vec(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0004, 0, 0);
    add_vec(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0004, 0, 0);
    add_vec(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].s_if, vq[i].s_id, vq[i].fl, vq[i].fl_pc, vq[i].br, vq[i].br_addr, vq[i].nd);
      tick();
      chk($sformatf("vec%0d pc", i), pc, vq[i].e_pc);
      chk($sformatf("vec%0d ds", i), {31'd0, delayslot_flag}, {31'd0, vq[i].e_ds});
      chk($sformatf("vec%0d pend", i), {31'd0, branch_pending}, {31'd0, vq[i].e_pend});
      chk($sformatf("vec%0d rom_en", i), {31'd0, rom_en}, 32'd1);
    end

`ifdef PC_ALIGN_CHECK_EN
    drive(0, 0, 0, '0, 1, 32'h0040_0022, 0);
    tick();
    chk("align pc seq", pc, 32'h0000_000C);
    chk("align err pulse", {31'd0, addr_err}, 32'd1);
    chk("align err pc", addr_err_pc, 32'h0040_0022);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick();
    chk("align err drop", {31'd0, addr_err}, 32'd0);
    chk("align err pc hold", addr_err_pc, 32'h0040_0022);
    chk("align pc next", pc, 32'h0000_0010);
`endif

    // Async reset mid-cycle while a branch is pending.
    drive(1, 0, 0, '0, 1, 32'h0070_0000, 0);
    tick();
    chk("pre-areset pend", {31'd0, branch_pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset pc", pc, 32'hBFC0_0000);
    chk("areset rom_en", {31'd0, rom_en}, 32'd0);
    chk("areset pend", {31'd0, branch_pending}, 32'd0);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick();
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < 800; c++) begin
      logic s_if, s_id, fl, br, nd;
      logic [31:0] fpc, badr;
      s_if = ($urandom_range(0, 2) == 0);
      s_id = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      br   = ($urandom_range(0, 3) == 0);
      nd   = ($urandom_range(0, 3) == 0);
      fpc  = $urandom & 32'hFFFF_FFFC;
      badr = $urandom & 32'hFFFF_FFFC;
      drive(s_if, s_id, fl, fpc, br, badr, nd);
      model_step();
      tick();
      chk($sformatf("rnd%0d pc", c), pc, m_pc);
      chk($sformatf("rnd%0d ds", c), {31'd0, delayslot_flag}, {31'd0, m_ds});
      chk($sformatf("rnd%0d pend", c), {31'd0, branch_pending}, {31'd0, m_pending});
      chk($sformatf("rnd%0d rom_en", c), {31'd0, rom_en}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
